// File: rtl/led_display_scan_ctrl.sv
// HUB75-style panel scan sequencer. Walks row pairs and BCM bit planes:
// request a column shift, pulse LAT, then un-blank for a plane-weighted time.
module led_display_scan_ctrl #(
  parameter int NUM_ROW_PIXELS = 32,
  parameter int NUM_COL_PIXELS = 64,
  parameter int COLOUR_DEPTH   = 4,
  parameter int BASE_ON_CYCLES = 16,
  parameter int LATCH_CYCLES   = 1,
  localparam int RA_W = $clog2(NUM_ROW_PIXELS / 2),
  localparam int PL_W = (COLOUR_DEPTH > 1) ? $clog2(COLOUR_DEPTH) : 1
) (
  input  logic            clk_in,
  input  logic            n_reset_in,
  input  logic            enable_in,
  input  logic            shift_done_in,
  output logic            shift_req_out,
  output logic [RA_W-1:0] shift_row_out,
  output logic [PL_W-1:0] shift_plane_out,
  output logic [RA_W-1:0] row_addr_out,
  output logic            latch_out,
  output logic            blank_out,
  output logic            frame_start_out,
  output logic            busy_out
);

  // Counter must hold the longest dwell (top plane) and the latch width.
  localparam int MAX_ON  = BASE_ON_CYCLES << (COLOUR_DEPTH - 1);
  localparam int CNT_MAX = (MAX_ON > LATCH_CYCLES) ? MAX_ON : LATCH_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  // Parameter sanity: the column count only matters to the PHY, but a
  // nonsensical panel geometry is still rejected at elaboration.
  if (NUM_ROW_PIXELS < 4 || (NUM_ROW_PIXELS & (NUM_ROW_PIXELS - 1)) != 0)
    begin : g_bad_rows   $error("NUM_ROW_PIXELS must be a power of two >= 4"); end
  if (NUM_COL_PIXELS < 1) begin : g_bad_cols  $error("NUM_COL_PIXELS must be >= 1"); end
  if (COLOUR_DEPTH < 1)   begin : g_bad_depth $error("COLOUR_DEPTH must be >= 1"); end
  if (BASE_ON_CYCLES < 1) begin : g_bad_base  $error("BASE_ON_CYCLES must be >= 1"); end
  if (LATCH_CYCLES < 1)   begin : g_bad_lat   $error("LATCH_CYCLES must be >= 1"); end

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_e;

  state_e            state_q, state_d;
  logic [RA_W-1:0]   row_q, row_d;
  logic [PL_W-1:0]   plane_q, plane_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              shift_req_q, latch_q, blank_q, fs_q, busy_q;
  logic [RA_W-1:0]   shift_row_q, row_addr_q;
  logic [PL_W-1:0]   shift_plane_q;

  logic [CNT_W:0]    on_cyc;
  logic              dwell_done, lat_done, last_plane, last_row;

  // BCM weight: plane p stays lit for BASE_ON_CYCLES * 2^p cycles.
  assign on_cyc     = (CNT_W+1)'(BASE_ON_CYCLES) << plane_q;
  assign dwell_done = (cnt_q == CNT_W'(on_cyc - (CNT_W+1)'(1)));
  assign lat_done   = (cnt_q == CNT_W'(LATCH_CYCLES - 1));
  assign last_plane = (plane_q == PL_W'(COLOUR_DEPTH - 1));
  assign last_row   = (row_q == RA_W'(NUM_ROW_PIXELS / 2 - 1));

  // Next-state and counter logic; enable is only honoured at a dwell boundary.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    plane_d = plane_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (enable_in) begin
          state_d = SHIFT;
          row_d   = '0;
          plane_d = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (shift_done_in) begin
          state_d = LATCH;
          cnt_d   = '0;
        end
      end
      LATCH: begin
        if (lat_done) begin
          state_d = DISPLAY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DISPLAY: begin
        if (dwell_done) begin
          cnt_d = '0;
          if (last_plane) begin
            plane_d = '0;
            row_d   = last_row ? '0 : row_q + RA_W'(1);
          end else begin
            plane_d = plane_q + PL_W'(1);
          end
          if (enable_in) begin
            state_d = SHIFT;
          end else begin
            state_d = IDLE;
            row_d   = '0;
            plane_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      state_q <= IDLE;
      row_q   <= '0;
      plane_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      plane_q <= plane_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs registered from the next state so they line up with the state.
  // Row address only moves on SHIFT->LATCH, i.e. while the panel is blanked.
  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      shift_req_q   <= 1'b0;
      shift_row_q   <= '0;
      shift_plane_q <= '0;
      row_addr_q    <= '0;
      latch_q       <= 1'b0;
      blank_q       <= 1'b1;
      fs_q          <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      shift_req_q   <= (state_d == SHIFT);
      shift_row_q   <= (state_d == SHIFT) ? row_d : '0;
      shift_plane_q <= (state_d == SHIFT) ? plane_d : '0;
      if (state_q == SHIFT && state_d == LATCH) row_addr_q <= row_q;
      latch_q       <= (state_d == LATCH);
      blank_q       <= (state_d != DISPLAY);
      fs_q          <= (state_d == SHIFT) && (state_q != SHIFT) &&
                       (row_d == '0) && (plane_d == '0);
      busy_q        <= (state_d != IDLE);
    end
  end

  assign shift_req_out   = shift_req_q;
  assign shift_row_out   = shift_row_q;
  assign shift_plane_out = shift_plane_q;
  assign row_addr_out    = row_addr_q;
  assign latch_out       = latch_q;
  assign blank_out       = blank_q;
  assign frame_start_out = fs_q;
  assign busy_out        = busy_q;

endmodule

// File: tb/tb_led_display_scan_ctrl.sv
// Bench for led_display_scan_ctrl: PHY model plus scan-order scoreboard.
module tb_led_display_scan_ctrl;
  localparam int ROWS = 32, COLS = 64, CD = 4, BASE = 16, LAT = 1;
  localparam int NRP  = ROWS / 2;

  logic       clk_in = 1'b0, n_reset_in = 1'b0, enable_in = 1'b0, shift_done_in = 1'b0;
  logic       shift_req_out, latch_out, blank_out, frame_start_out, busy_out;
  logic [3:0] shift_row_out, row_addr_out;
  logic [1:0] shift_plane_out;

  led_display_scan_ctrl #(
    .NUM_ROW_PIXELS(ROWS), .NUM_COL_PIXELS(COLS), .COLOUR_DEPTH(CD),
    .BASE_ON_CYCLES(BASE), .LATCH_CYCLES(LAT)
  ) dut (
    .clk_in(clk_in), .n_reset_in(n_reset_in), .enable_in(enable_in),
    .shift_done_in(shift_done_in), .shift_req_out(shift_req_out),
    .shift_row_out(shift_row_out), .shift_plane_out(shift_plane_out),
    .row_addr_out(row_addr_out), .latch_out(latch_out), .blank_out(blank_out),
    .frame_start_out(frame_start_out), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0, errors = 0;
  int cyc = 0, phy_delay = 64, last_fs = -1;
  int shift_k = 0, shift_run = 0, latch_run = 0, blank_run = 0;
  int model_row = 0, model_plane = 0, disp_row = -1, disp_plane = -1;
  bit noise_en = 0, done_acc = 0;
  bit p_req = 0, p_latch = 0, p_blank = 1;
  int p_ra = 0;
  int q_ra[$];
  int q_w[$];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic int frame_len(input int d);
    return NRP * (CD * (d + 1 + LAT) + BASE * ((1 << CD) - 1));
  endfunction

  task automatic reset_chk(input string t);
    chk({t, "_blank"},  int'(blank_out), 1);
    chk({t, "_req"},    int'(shift_req_out), 0);
    chk({t, "_srow"},   int'(shift_row_out), 0);
    chk({t, "_splane"}, int'(shift_plane_out), 0);
    chk({t, "_ra"},     int'(row_addr_out), 0);
    chk({t, "_latch"},  int'(latch_out), 0);
    chk({t, "_fs"},     int'(frame_start_out), 0);
    chk({t, "_busy"},   int'(busy_out), 0);
  endtask

  // One clock: sample on the falling edge, check, then play the PHY.
  task automatic tick();
    bit req, lat, blk, fs;
    int ra;
    @(negedge clk_in);
    cyc++;
    req = shift_req_out; lat = latch_out; blk = blank_out; fs = frame_start_out;
    ra  = int'(row_addr_out);

    if (req && !p_req) begin
      chk("shift_row",   int'(shift_row_out),   model_row);
      chk("shift_plane", int'(shift_plane_out), model_plane);
      chk("fstart",      int'(fs), int'(model_row == 0 && model_plane == 0));
      shift_run = 0;
    end else if (fs) chk("fstart_stray", int'(fs), 0);
    if (fs) begin
      if (last_fs >= 0) chk("fs_period", cyc - last_fs, frame_len(phy_delay));
      last_fs = cyc;
    end

    if (req) shift_run++;
    else if (p_req) chk("shift_len", shift_run, phy_delay + 1);

    if (done_acc) chk("latch_after_done", int'(lat && !p_latch), 1);
    else if (lat && !p_latch) chk("latch_unreq", int'(lat), 0);
    if (lat && !p_latch) begin
      latch_run = 0;
      if (q_ra.size() > 0) chk("row_addr", ra, q_ra.pop_front());
      else chk("ra_sb_empty", q_ra.size(), 1);
    end
    if (lat) latch_run++;
    else if (p_latch) chk("latch_len", latch_run, LAT);

    if (ra != p_ra) begin
      chk("ra_chg_blank", int'(blk), 1);
      chk("ra_chg_latch", int'(lat), 1);
    end

    if (!blk) begin
      if (p_blank) blank_run = 0;
      blank_run++;
      chk("overlap", int'(req || lat), 0);
    end else if (!p_blank) begin
      if (q_w.size() > 0) chk("on_width", blank_run, q_w.pop_front());
      else chk("w_sb_empty", q_w.size(), 1);
    end

    // PHY model: finish the shift phy_delay cycles after the request rises.
    done_acc = 0;
    shift_done_in = 1'b0;
    if (req) begin
      shift_k = p_req ? shift_k + 1 : 0;
      if (shift_k == phy_delay) begin
        shift_done_in = 1'b1;
        done_acc = 1;
        q_ra.push_back(model_row);
        q_w.push_back(BASE << model_plane);
        disp_row = model_row; disp_plane = model_plane;
        if (model_plane == CD - 1) begin
          model_plane = 0;
          model_row = (model_row + 1) % NRP;
        end else model_plane++;
      end
    end else if (noise_en && (cyc % 3 == 0)) shift_done_in = 1'b1;

    p_req = req; p_latch = lat; p_blank = blk; p_ra = ra;
  endtask

  task automatic wait_latch(input string tag);
    int n = 0;
    while (!latch_out && n < 400) begin tick(); n++; end
    chk(tag, int'(latch_out), 1);
  endtask

  initial begin
    int n;
    repeat (2) tick();
    reset_chk("rst");
    n_reset_in = 1'b1;
    repeat (100) tick();
    reset_chk("idle100");

    // Continuous scan, two full frames plus margin.
    enable_in = 1'b1;
    repeat (2 * frame_len(64) + 200) tick();

    // Stray shift_done pulses outside SHIFT must not disturb anything.
    noise_en = 1;
    repeat (frame_len(64) + 100) tick();
    noise_en = 0;

    // Zero-latency PHY: SHIFT collapses to a single cycle.
    wait_latch("wait_latch0");
    phy_delay = 0; last_fs = -1;
    repeat (300) tick();
    wait_latch("wait_latch64");
    phy_delay = 64; last_fs = -1;

    // Drop enable during row 5 plane 2 display.
    n = 0;
    while (!(blank_out == 1'b0 && disp_row == 5 && disp_plane == 2) && n < 20000) begin
      tick(); n++;
    end
    chk("wait_r5p2", int'(n < 20000), 1);
    enable_in = 1'b0;
    model_row = 0; model_plane = 0; last_fs = -1;
    repeat (80) tick();
    chk("dis_busy",  int'(busy_out), 0);
    chk("dis_blank", int'(blank_out), 1);
    chk("dis_req",   int'(shift_req_out), 0);
    chk("dis_q",     q_w.size(), 0);

    // Re-enable starts a fresh frame one cycle later.
    enable_in = 1'b1;
    n = 0;
    while (!shift_req_out && n < 5) begin tick(); n++; end
    chk("reen_lat",   n, 1);
    chk("reen_fs",    int'(frame_start_out), 1);
    chk("reen_row",   int'(shift_row_out), 0);
    chk("reen_plane", int'(shift_plane_out), 0);
    repeat (500) tick();

    // Asynchronous reset in the middle of a display dwell.
    n = 0;
    while (blank_out && n < 400) begin tick(); n++; end
    chk("wait_disp", int'(blank_out), 0);
    #2 n_reset_in = 1'b0;
    #1 reset_chk("mid_rst");
    q_ra.delete(); q_w.delete();
    model_row = 0; model_plane = 0; last_fs = -1;
    done_acc = 0; shift_done_in = 1'b0;
    p_req = 0; p_latch = 0; p_blank = 1; p_ra = 0;
    blank_run = 0; shift_run = 0; latch_run = 0;
    repeat (3) tick();
    n_reset_in = 1'b1;
    n = 0;
    while (!shift_req_out && n < 5) begin tick(); n++; end
    chk("rst_resume_row",   int'(shift_row_out), 0);
    chk("rst_resume_plane", int'(shift_plane_out), 0);
    chk("rst_resume_fs",    int'(frame_start_out), 1);
    repeat (600) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
